rx_bit_timer: RTL and testbench
===============================

Name: rx_bit_timer

Overview:
- Sampling timer for the serial receive path. Sits between the start-bit detector and the receive shift register.
- After a start pulse, it waits half a bit period to centre on the bit. It then issues one shift_strobe per bit period until num_bits strobes have been issued, and finally pulses packet_done.
- Drives the shift register's shift enable and the packet-check FSM.

Parameters:
- DIV_BITS, 8, width of the clocks-per-bit divisor.
- CNT_BITS, 4, width of the bits-per-packet count.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle pulse from start-bit detector; ignored while busy.
- abort  input  1  level; forces return to idle.
- clk_div  input  DIV_BITS  clocks per bit period; latched on accepted start.
- num_bits  input  CNT_BITS  strobes per packet (data + stop); latched on accepted start.
- busy  output  1  high from the cycle after an accepted start until the packet_done cycle (exclusive).
- shift_strobe  output  1  one-cycle pulse at each bit centre.
- packet_done  output  1  one-cycle pulse after the final strobe.
- bit_cnt  output  CNT_BITS  number of strobes issued in the current packet.

Behaviour:
- Reset: n_rst sampled low at a rising edge gives state IDLE and busy=0, shift_strobe=0, packet_done=0, bit_cnt=0. The latched divisor and count are cleared. Reset has priority over all other inputs, including mid-packet.
- All outputs are registered. No combinational path from input to output.
- Divisor rules:
  - Latched divisor D = max(clk_div, 2).
  - Half period H = D >> 1.
  - Latched count N = num_bits.
- Start acceptance: start is accepted only in IDLE with num_bits != 0. Start with num_bits == 0 is ignored; state stays IDLE.
- States: IDLE, ALIGN, SAMPLE, DONE.
- IDLE:
  - Accepted start at edge E0 gives ALIGN, busy=1, bit_cnt=0, phase counter cleared.
- ALIGN:
  - Phase counts 1..H.
  - On the edge where phase reaches H, go to SAMPLE with phase cleared.
  - No strobe in ALIGN.
- SAMPLE:
  - Phase counts 1..D.
  - On the edge where phase reaches D: shift_strobe=1 for one cycle, bit_cnt increments, phase clears.
  - If the incremented bit_cnt equals N, go to DONE on that same edge.
- DONE:
  - One cycle long. On the next edge: packet_done=1 for one cycle, busy=0, state IDLE.
  - bit_cnt holds N until the next accepted start.
- Timing with start at E0:
  - Strobe k (k=1..N) is asserted after edge E0+H+k*D.
  - packet_done is asserted after edge E0+H+N*D+1.
- Abort:
  - Level-sensitive, priority over start.
  - In any non-IDLE state, the next edge gives IDLE, busy=0, bit_cnt=0.
  - No shift_strobe or packet_done is generated on that edge, even if a phase rollover coincides.
- Start while busy: ignored; no effect on phase or bit_cnt.
- Start in the same cycle as packet_done (state IDLE): accepted normally.
- Input changes while busy: clk_div and num_bits changes have no effect until the next accepted start.
- Width rules:
  - Phase counter is DIV_BITS wide.
  - bit_cnt is CNT_BITS wide and never wraps, because N ≤ 2^CNT_BITS−1.

Decomposition:
- Package rx_timer_pkg holds:
  - typedef enum logic [1:0] rx_timer_state_t {IDLE, ALIGN, SAMPLE, DONE};
  - localparam MIN_DIV = 2.
- Sub-module rx_phase_counter is a parameterised up-counter with:
  - synchronous active-low reset;
  - clear, enable and a rollover_val input;
  - a registered rollover pulse.
- rx_phase_counter is used for the phase count.
- bit_cnt and the FSM live in the top.

Test Plan:
- Reset mid-packet: start with clk_div=10, num_bits=9, then hold n_rst low at E0+40 → all outputs 0 at the next edge. No strobe afterwards without a new start.
- Nominal packet: clk_div=10, num_bits=9, start at E0 → strobes after E0+15, 25, …, 95 (9 pulses); packet_done after E0+96; busy low from E0+96; bit_cnt=9.
- Minimum divisor: clk_div=1 (treated as 2), num_bits=3 → H=1; strobes after E0+3, 5, 7; packet_done after E0+8.
- Start ignored: start pulsed at E0+20 during a packet, then start with num_bits=0 in IDLE → strobe timing unchanged; busy stays 0 for the num_bits=0 start.
- Abort on rollover: clk_div=4, num_bits=4, abort asserted in the cycle whose edge would issue strobe 2 (E0+10) → no strobe, no packet_done; busy=0, bit_cnt=0 at the next edge.
- Back-to-back packets plus mid-packet input change: start again in the packet_done cycle, with clk_div changed to 6 mid-packet → first packet keeps D=4; second packet uses D=6 with strobes spaced 6 cycles apart.

Source files
------------

// File: rtl/rx_timer_pkg.sv
// rx_timer_pkg: shared types and constants for the receive bit timer.
//   rx_timer_state_t : sequencing states of rx_bit_timer
//   MIN_DIV          : smallest divisor the timer will run with
package rx_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SAMPLE,
    DONE
  } rx_timer_state_t;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/rx_phase_counter.sv
// rx_phase_counter: phase up-counter with a registered rollover pulse.
//   clk_i          : clock, rising edge
//   n_rst_i        : synchronous active-low reset
//   clr_i          : clear count to zero (priority over enable)
//   en_i           : advance the count by one
//   rollover_val_i : number of counts per phase period for the coming cycle
//   rollover_o     : registered; high during the cycle whose closing edge
//                    brings the phase to rollover_val_i (count clears there)
module rx_phase_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] rollover_val_i,
  output logic             rollover_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             roll_q, roll_d;
  logic [WIDTH:0]   count_inc;

  // The pulse is precomputed one cycle ahead from the next count value so
  // that the consumer can act on the very edge where the phase reaches the
  // target while still seeing a flop output. rollover_val_i must therefore
  // carry the target that applies in the following cycle.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = roll_q ? '0 : count_q + WIDTH'(1);
    end
    count_inc = {1'b0, count_d} + (WIDTH + 1)'(1);
    roll_d    = (count_inc == {1'b0, rollover_val_i});
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      count_q <= '0;
      roll_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      roll_q  <= roll_d;
    end
  end

  assign rollover_o = roll_q;

endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: sampling timer for the serial receive path.
// After an accepted start it waits half a bit period, then pulses
// shift_strobe once per bit period until num_bits strobes have been issued,
// then pulses packet_done.
//   clk          : system clock, rising edge
//   n_rst        : synchronous active-low reset
//   start        : one-cycle start pulse; ignored while busy
//   abort        : level; returns the timer to idle
//   clk_div      : clocks per bit period, latched on accepted start
//   num_bits     : strobes per packet, latched on accepted start
//   busy         : packet in progress
//   shift_strobe : one-cycle pulse at each bit centre
//   packet_done  : one-cycle pulse after the final strobe
//   bit_cnt      : strobes issued in the current packet
module rx_bit_timer
  import rx_timer_pkg::*;
#(
  parameter int unsigned DIV_BITS = 8,
  parameter int unsigned CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [DIV_BITS-1:0] clk_div,
  input  logic [CNT_BITS-1:0] num_bits,
  output logic                busy,
  output logic                shift_strobe,
  output logic                packet_done,
  output logic [CNT_BITS-1:0] bit_cnt
);

  rx_timer_state_t state_q, state_d;

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [CNT_BITS-1:0] num_q, num_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_BITS-1:0] bit_cnt_inc;
  logic                busy_q, busy_d;
  logic                strobe_q, strobe_d;
  logic                done_q, done_d;

  logic [DIV_BITS-1:0] div_in;
  logic                ph_clr;
  logic                ph_en;
  logic [DIV_BITS-1:0] ph_target;
  logic                ph_roll;

  rx_phase_counter #(
    .WIDTH (DIV_BITS)
  ) u_phase (
    .clk_i          (clk),
    .n_rst_i        (n_rst),
    .clr_i          (ph_clr),
    .en_i           (ph_en),
    .rollover_val_i (ph_target),
    .rollover_o     (ph_roll)
  );

  assign div_in      = (clk_div < DIV_BITS'(MIN_DIV)) ? DIV_BITS'(MIN_DIV) : clk_div;
  assign bit_cnt_inc = bit_cnt_q + CNT_BITS'(1);
  assign ph_en       = (state_q == ALIGN) || (state_q == SAMPLE);

  // ph_target follows the state being entered, since the phase counter
  // evaluates its rollover one cycle ahead.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    num_d     = num_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    ph_clr    = 1'b0;
    ph_target = div_q;

    case (state_q)
      IDLE: begin
        if (start && !abort && (num_bits != '0)) begin
          state_d   = ALIGN;
          div_d     = div_in;
          num_d     = num_bits;
          bit_cnt_d = '0;
          ph_clr    = 1'b1;
          ph_target = div_in >> 1;
        end
      end
      ALIGN: begin
        ph_target = div_q >> 1;
        if (ph_roll) begin
          state_d   = SAMPLE;
          ph_target = div_q;
        end
      end
      SAMPLE: begin
        ph_target = div_q;
        if (ph_roll) begin
          strobe_d  = 1'b1;
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == num_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the state logic decided, including a
    // coincident strobe or packet_done.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      ph_clr    = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      num_q     <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      num_q     <= num_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  assign busy         = busy_q;
  assign shift_strobe = strobe_q;
  assign packet_done  = done_q;
  assign bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: scoreboard bench for rx_bit_timer. Expected strobe and
// packet_done events (edge number and bit_cnt) are queued when a start is
// driven and matched against the DUT output events as they appear.
module tb_rx_bit_timer;

  localparam int unsigned DIV_BITS = 8;
  localparam int unsigned CNT_BITS = 4;

  logic                clk;
  logic                n_rst;
  logic                start;
  logic                abort;
  logic [DIV_BITS-1:0] clk_div;
  logic [CNT_BITS-1:0] num_bits;
  logic                busy;
  logic                shift_strobe;
  logic                packet_done;
  logic [CNT_BITS-1:0] bit_cnt;

  typedef struct {
    int cyc;
    int is_done;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  rx_bit_timer #(
    .DIV_BITS (DIV_BITS),
    .CNT_BITS (CNT_BITS)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .clk_div      (clk_div),
    .num_bits     (num_bits),
    .busy         (busy),
    .shift_strobe (shift_strobe),
    .packet_done  (packet_done),
    .bit_cnt      (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue the events of one packet started at edge e0. Only the first kmax
  // strobes are queued; packet_done only when with_done is set.
  task automatic push_exp(input int e0, input int div, input int n,
                          input int kmax, input int with_done);
    int d;
    int h;
    exp_t e;
    d = (div < 2) ? 2 : div;
    h = d / 2;
    for (int k = 1; k <= kmax; k++) begin
      e.cyc = e0 + h + k * d;
      e.is_done = 0;
      e.cnt = k;
      exp_q.push_back(e);
    end
    if (with_done != 0) begin
      e.cyc = e0 + h + n * d + 1;
      e.is_done = 1;
      e.cnt = n;
      exp_q.push_back(e);
    end
  endtask

  // Called at a falling edge; the start is sampled at the next rising edge.
  task automatic start_pkt(input int div, input int n, output int e0);
    clk_div  = DIV_BITS'(div);
    num_bits = CNT_BITS'(n);
    start    = 1'b1;
    e0       = cyc + 1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Output event monitor.
  always @(negedge clk) begin
    exp_t e;
    if (shift_strobe || packet_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, shift_strobe, packet_done}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_edge", cyc, e.cyc);
        chk("event_is_done", int'(packet_done), e.is_done);
        chk("event_bit_cnt", int'(bit_cnt), e.cnt);
        if (e.is_done != 0) chk("busy_at_done", int'(busy), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0;
    int e1;
    n_cmp    = 0;
    n_err    = 0;
    n_rst    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    clk_div  = 8'd10;
    num_bits = 4'd9;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobe", int'(shift_strobe), 0);
    chk("rst_done", int'(packet_done), 0);
    chk("rst_bit_cnt", int'(bit_cnt), 0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-packet
    start_pkt(10, 9, e0);
    push_exp(e0, 10, 9, 3, 0);
    wait_cyc(e0 + 39);
    n_rst = 1'b0;
    wait_cyc(e0 + 40);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_strobe", int'(shift_strobe), 0);
    chk("midrst_done", int'(packet_done), 0);
    chk("midrst_bit_cnt", int'(bit_cnt), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (80) @(negedge clk);
    chk("midrst_pending", exp_q.size(), 0);

    // Nominal packet
    start_pkt(10, 9, e0);
    push_exp(e0, 10, 9, 9, 1);
    chk("nom_busy_start", int'(busy), 1);
    chk("nom_bit_cnt_start", int'(bit_cnt), 0);
    wait_cyc(e0 + 95);
    chk("nom_busy_last", int'(busy), 1);
    wait_cyc(e0 + 96);
    chk("nom_busy_end", int'(busy), 0);
    wait_cyc(e0 + 104);
    chk("nom_bit_cnt_hold", int'(bit_cnt), 9);
    chk("nom_pending", exp_q.size(), 0);

    // Minimum divisor
    start_pkt(1, 3, e0);
    push_exp(e0, 1, 3, 3, 1);
    wait_cyc(e0 + 12);
    chk("min_pending", exp_q.size(), 0);
    chk("min_bit_cnt", int'(bit_cnt), 3);

    // Start ignored while busy, then a zero-length start in idle
    start_pkt(10, 3, e0);
    push_exp(e0, 10, 3, 3, 1);
    wait_cyc(e0 + 19);
    clk_div  = 8'd3;
    num_bits = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_cyc(e0 + 45);
    chk("ign_pending", exp_q.size(), 0);
    chk("ign_bit_cnt", int'(bit_cnt), 3);
    start_pkt(10, 0, e1);
    chk("zero_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("zero_busy_later", int'(busy), 0);
    chk("zero_bit_cnt", int'(bit_cnt), 3);

    // Abort on the edge that would issue strobe 2
    start_pkt(4, 4, e0);
    push_exp(e0, 4, 4, 1, 0);
    wait_cyc(e0 + 9);
    abort = 1'b1;
    wait_cyc(e0 + 10);
    chk("abort_busy", int'(busy), 0);
    chk("abort_bit_cnt", int'(bit_cnt), 0);
    chk("abort_strobe", int'(shift_strobe), 0);
    @(negedge clk);
    abort = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_pending", exp_q.size(), 0);
    chk("abort_busy_later", int'(busy), 0);

    // Back-to-back packets with inputs changed mid-packet
    start_pkt(4, 4, e0);
    push_exp(e0, 4, 4, 4, 1);
    wait_cyc(e0 + 8);
    clk_div  = 8'd6;
    num_bits = 4'd2;
    wait_cyc(e0 + 19);
    chk("b2b_done_cycle", int'(packet_done), 1);
    start_pkt(6, 2, e1);
    push_exp(e1, 6, 2, 2, 1);
    chk("b2b_busy_second", int'(busy), 1);
    chk("b2b_bit_cnt_second", int'(bit_cnt), 0);
    wait_cyc(e1 + 24);
    chk("b2b_pending", exp_q.size(), 0);
    chk("b2b_bit_cnt", int'(bit_cnt), 2);
    chk("b2b_busy_end", int'(busy), 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
